// File: rtl/tankb_pkg.sv
// Shared definitions for the tank-battle video subsystem.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Holds the screen-RAM loader state encoding and the playfield image
// constants that the top level uses as its parameter values.
package tankb_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_XFER = 2'd2;
    localparam logic [1:0] ST_FIN  = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE = ST_IDLE,
        S_REQ  = ST_REQ,
        S_XFER = ST_XFER,
        S_FIN  = ST_FIN
    } loader_state_t;

    // Playfield region of screen RAM filled from the screen-image ROM.
    localparam logic [10:0] SCREEN_RAM_BASE = 11'h000;
    localparam int          SCREEN_WORDS    = 1024;

endpackage

// File: rtl/screen_ram_loader.sv
// Copies WORDS bytes from the 2K screen-image ROM into screen RAM after a start pulse.
// Latency: bus_req 1 cycle after start, first write 3 cycles after start, done at 3+WORDS (gnt held high).
// Backpressure: bus_gnt low stalls both ROM issue and RAM write; the ROM holds the in-flight byte.
//
// Ports:
//   clk, reset            sole clock, synchronous active-high reset
//   start                 one-cycle request; ignored unless idle
//   busy, done            transfer in progress / one-cycle completion pulse
//   bus_req, bus_gnt      screen-RAM bus handshake; grant may drop any cycle
//   rom_addr, rom_n_cs    ROM read port (address registered, n_cs high = hold q)
//   rom_q                 ROM data, valid the cycle after an issue
//   ram_addr, ram_data,
//   ram_we                screen-RAM write port, one byte per granted cycle
module screen_ram_loader
    import tankb_pkg::*;
#(
    parameter logic [10:0] ROM_BASE = 11'h000,
    parameter logic [10:0] RAM_BASE = SCREEN_RAM_BASE,
    parameter int          WORDS    = SCREEN_WORDS
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        bus_req,
    input  logic        bus_gnt,
    output logic [10:0] rom_addr,
    output logic        rom_n_cs,
    input  logic [7:0]  rom_q,
    output logic [10:0] ram_addr,
    output logic [7:0]  ram_data,
    output logic        ram_we
);

    localparam int            CW      = $clog2(WORDS) + 1;
    localparam logic [CW-1:0] WORDS_C = CW'(WORDS);
    localparam logic [CW-1:0] LAST_WR = CW'(WORDS - 1);

    if (WORDS < 1 || WORDS > 2048 ||
        int'(ROM_BASE) + WORDS > 2048 || int'(RAM_BASE) + WORDS > 2048) begin : g_bad_params
        $error("screen_ram_loader: transfer window exceeds the 2K address space");
    end

    loader_state_t state_q, state_d;
    logic [CW-1:0] issue_cnt_q, issue_cnt_d;
    logic [CW-1:0] wr_cnt_q, wr_cnt_d;
    logic          pending_q, pending_d;
    logic [10:0]   rom_addr_q, rom_addr_d;
    logic          issue_en;
    logic          wr_en;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            issue_cnt_q <= '0;
            wr_cnt_q    <= '0;
            pending_q   <= 1'b0;
            rom_addr_q  <= ROM_BASE;
        end else begin
            state_q     <= state_d;
            issue_cnt_q <= issue_cnt_d;
            wr_cnt_q    <= wr_cnt_d;
            pending_q   <= pending_d;
            rom_addr_q  <= rom_addr_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        issue_cnt_d = issue_cnt_q;
        wr_cnt_d    = wr_cnt_q;
        pending_d   = pending_q;
        issue_en    = 1'b0;
        wr_en       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                if (bus_gnt) begin
                    state_d = S_XFER;
                end
            end
            S_XFER: begin
                // Issue and write only advance on granted cycles; while the
                // grant is away the ROM keeps the last issued byte on rom_q.
                issue_en = bus_gnt && (issue_cnt_q != WORDS_C);
                wr_en    = bus_gnt && pending_q;
                if (issue_en) begin
                    issue_cnt_d = issue_cnt_q + 1'b1;
                end
                if (wr_en) begin
                    wr_cnt_d = wr_cnt_q + 1'b1;
                end
                // A write and a fresh issue in the same cycle leave one byte in flight.
                if (issue_en) begin
                    pending_d = 1'b1;
                end else if (wr_en) begin
                    pending_d = 1'b0;
                end
                if (wr_en && wr_cnt_q == LAST_WR) begin
                    state_d = S_FIN;
                end
            end
            S_FIN: begin
                state_d     = S_IDLE;
                issue_cnt_d = '0;
                wr_cnt_d    = '0;
                pending_d   = 1'b0;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // The address register always points at the next byte to issue.
        rom_addr_d = ROM_BASE + 11'(issue_cnt_d);
    end

    assign busy     = (state_q == S_REQ) || (state_q == S_XFER);
    assign bus_req  = busy;
    assign done     = (state_q == S_FIN);
    assign rom_addr = rom_addr_q;
    assign rom_n_cs = ~issue_en;
    assign ram_we   = wr_en;
    assign ram_addr = RAM_BASE + 11'(wr_cnt_q);
    assign ram_data = rom_q;

endmodule

// File: tb/tb_screen_ram_loader.sv
// Self-checking bench for screen_ram_loader with a registered 2K ROM model.
// Three instances: 4-byte window, 1-byte window at the top of ROM, full 2K image.
module tb_screen_ram_loader;

    localparam logic [10:0] A_ROM = 11'h100;
    localparam logic [10:0] A_RAM = 11'h040;
    localparam int          A_W   = 4;
    localparam logic [10:0] B_ROM = 11'h7FF;
    localparam logic [10:0] B_RAM = 11'h123;
    localparam int          B_W   = 1;
    localparam int          C_W   = 2048;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset = 1'b1;

    logic        start_a = 1'b0, gnt_a = 1'b0, busy_a, done_a, req_a, ncs_a, we_a;
    logic [10:0] rom_addr_a, ram_addr_a;
    logic [7:0]  rom_q_a = 8'h00, ram_data_a;
    logic        start_b = 1'b0, gnt_b = 1'b0, busy_b, done_b, req_b, ncs_b, we_b;
    logic [10:0] rom_addr_b, ram_addr_b;
    logic [7:0]  rom_q_b = 8'h00, ram_data_b;
    logic        start_c = 1'b0, gnt_c = 1'b0, busy_c, done_c, req_c, ncs_c, we_c;
    logic [10:0] rom_addr_c, ram_addr_c;
    logic [7:0]  rom_q_c = 8'h00, ram_data_c;

    logic [7:0] rom_mem [2048];
    logic [7:0] ram_c   [2048];

    int checks = 0;
    int errors = 0;
    int wcnt_a = 0, wcnt_b = 0, wcnt_c = 0;
    int dcnt_a = 0, dcnt_b = 0, dcnt_c = 0;
    int idx_a = 0, idx_b = 0, idx_c = 0;

    screen_ram_loader #(.ROM_BASE(A_ROM), .RAM_BASE(A_RAM), .WORDS(A_W)) u_dut_a (
        .clk(clk), .reset(reset), .start(start_a), .busy(busy_a), .done(done_a),
        .bus_req(req_a), .bus_gnt(gnt_a), .rom_addr(rom_addr_a), .rom_n_cs(ncs_a),
        .rom_q(rom_q_a), .ram_addr(ram_addr_a), .ram_data(ram_data_a), .ram_we(we_a));

    screen_ram_loader #(.ROM_BASE(B_ROM), .RAM_BASE(B_RAM), .WORDS(B_W)) u_dut_b (
        .clk(clk), .reset(reset), .start(start_b), .busy(busy_b), .done(done_b),
        .bus_req(req_b), .bus_gnt(gnt_b), .rom_addr(rom_addr_b), .rom_n_cs(ncs_b),
        .rom_q(rom_q_b), .ram_addr(ram_addr_b), .ram_data(ram_data_b), .ram_we(we_b));

    screen_ram_loader #(.ROM_BASE(11'h000), .RAM_BASE(11'h000), .WORDS(C_W)) u_dut_c (
        .clk(clk), .reset(reset), .start(start_c), .busy(busy_c), .done(done_c),
        .bus_req(req_c), .bus_gnt(gnt_c), .rom_addr(rom_addr_c), .rom_n_cs(ncs_c),
        .rom_q(rom_q_c), .ram_addr(ram_addr_c), .ram_data(ram_data_c), .ram_we(we_c));

    // 2716-style ROM: q registered, held while n_cs is high.
    always @(posedge clk) begin
        if (!ncs_a) rom_q_a <= rom_mem[rom_addr_a];
        if (!ncs_b) rom_q_b <= rom_mem[rom_addr_b];
        if (!ncs_c) rom_q_c <= rom_mem[rom_addr_c];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model of a transfer: the n-th write of a transfer must carry
    // rom[ROM_BASE+n] to RAM_BASE+n, only on granted cycles, and done follows
    // exactly WORDS writes.
    always @(negedge clk) begin
        if (reset) begin
            idx_a = 0; idx_b = 0; idx_c = 0;
        end else begin
            if (we_a) begin
                wcnt_a++;
                check("a_wr_addr", 32'(ram_addr_a), 32'(A_RAM + 11'(idx_a)));
                check("a_wr_data", 32'(ram_data_a), 32'(rom_mem[A_ROM + 11'(idx_a)]));
                check("a_we_needs_gnt", 32'(gnt_a), 32'd1);
                idx_a++;
            end
            if (done_a) begin
                dcnt_a++;
                check("a_writes_per_xfer", 32'(idx_a), 32'(A_W));
                idx_a = 0;
            end
            if (we_b) begin
                wcnt_b++;
                check("b_wr_addr", 32'(ram_addr_b), 32'(B_RAM + 11'(idx_b)));
                check("b_wr_data", 32'(ram_data_b), 32'(rom_mem[B_ROM + 11'(idx_b)]));
                idx_b++;
            end
            if (done_b) begin
                dcnt_b++;
                check("b_writes_per_xfer", 32'(idx_b), 32'(B_W));
                idx_b = 0;
            end
            if (we_c) begin
                wcnt_c++;
                ram_c[ram_addr_c] = ram_data_c;
                if (!gnt_c) check("c_we_needs_gnt", 32'(gnt_c), 32'd1);
                idx_c++;
            end
            if (done_c) begin
                dcnt_c++;
                idx_c = 0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // gmode: 0 hold grant, 1 toggle gnt_c, 2 random gnt_a plus stray start pulses.
    task automatic run_until_done(input int sel, input int budget, input int gmode);
        bit seen = 1'b0;
        int grants = 0;
        for (int n = 0; n < budget && !seen; n++) begin
            @(negedge clk);
            case (sel)
                0:       seen = done_a;
                1:       seen = done_b;
                default: seen = done_c;
            endcase
            if (gmode == 2) begin
                // One grant to leave REQ, one for the first issue, one per byte written.
                if (seen) check("a_done_after_grants", 32'(grants), 32'(A_W + 2));
                else if (gnt_a) grants++;
            end
            tick();
            if (!seen) begin
                if (gmode == 1) gnt_c = ~gnt_c;
                if (gmode == 2) begin
                    gnt_a   = ($urandom_range(0, 2) != 0);
                    start_a = ($urandom_range(0, 5) == 0);
                end
            end
        end
        start_a = 1'b0;
        check("done_within_budget", 32'(seen), 32'd1);
    endtask

    typedef struct {
        logic start; logic gnt;
        logic busy; logic done; logic req; logic ncs; logic we;
        int   iss; int wr;
    } vec_t;

    initial begin
        vec_t tbl[10];
        int   w0, d0, mism;

        for (int i = 0; i < 2048; i++) rom_mem[i] = 8'($urandom);

        // Cycle-exact run on the 4-byte window with grant held high; start
        // pulses at cycle 4 (busy) and cycle 7 (FIN) must be ignored.
        //          st gnt bsy dn req ncs we iss wr
        tbl[0] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 0};
        tbl[1] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 0, 0};
        tbl[2] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 0, 0};
        tbl[3] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1, 0};
        tbl[4] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 2, 1};
        tbl[5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 3, 2};
        tbl[6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 0, 3};
        tbl[7] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 0, 0};
        tbl[8] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 0};
        tbl[9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 0};

        // Reset with start and grant asserted: reset wins.
        reset = 1'b1; start_a = 1'b1; gnt_a = 1'b1;
        repeat (2) tick();
        @(negedge clk);
        check("rst_busy",     32'(busy_a), 32'd0);
        check("rst_done",     32'(done_a), 32'd0);
        check("rst_bus_req",  32'(req_a),  32'd0);
        check("rst_rom_n_cs", 32'(ncs_a),  32'd1);
        check("rst_ram_we",   32'(we_a),   32'd0);
        check("rst_rom_addr", 32'(rom_addr_a), 32'(A_ROM));
        check("rst_rom_addr_b", 32'(rom_addr_b), 32'(B_ROM));
        tick();
        reset = 1'b0; start_a = 1'b0;
        @(negedge clk);
        check("start_with_reset_busy", 32'(busy_a), 32'd0);
        tick();

        w0 = wcnt_a; d0 = dcnt_a;
        for (int i = 0; i < 10; i++) begin
            start_a = tbl[i].start;
            gnt_a   = tbl[i].gnt;
            @(negedge clk);
            check($sformatf("tbl%0d_busy", i),    32'(busy_a), 32'(tbl[i].busy));
            check($sformatf("tbl%0d_done", i),    32'(done_a), 32'(tbl[i].done));
            check($sformatf("tbl%0d_bus_req", i), 32'(req_a),  32'(tbl[i].req));
            check($sformatf("tbl%0d_rom_n_cs", i), 32'(ncs_a), 32'(tbl[i].ncs));
            check($sformatf("tbl%0d_ram_we", i),  32'(we_a),   32'(tbl[i].we));
            if (!tbl[i].ncs)
                check($sformatf("tbl%0d_rom_addr", i), 32'(rom_addr_a), 32'(A_ROM + 11'(tbl[i].iss)));
            if (tbl[i].we)
                check($sformatf("tbl%0d_ram_addr", i), 32'(ram_addr_a), 32'(A_RAM + 11'(tbl[i].wr)));
            tick();
        end
        start_a = 1'b0;
        check("tbl_write_count", 32'(wcnt_a - w0), 32'd4);
        check("tbl_done_count",  32'(dcnt_a - d0), 32'd1);

        // Grant withdrawn for 5 cycles after the second write.
        w0 = wcnt_a; d0 = dcnt_a;
        start_a = 1'b1; gnt_a = 1'b1;
        tick(); start_a = 1'b0;
        repeat (4) tick();
        gnt_a = 1'b0;
        repeat (5) begin
            @(negedge clk);
            check("stall_ram_we",   32'(we_a),  32'd0);
            check("stall_rom_n_cs", 32'(ncs_a), 32'd1);
            check("stall_bus_req",  32'(req_a), 32'd1);
            tick();
        end
        gnt_a = 1'b1;
        @(negedge clk);
        check("resume_ram_we",   32'(we_a), 32'd1);
        check("resume_ram_addr", 32'(ram_addr_a), 32'(A_RAM + 11'd2));
        run_until_done(0, 20, 0);
        check("stall_write_count", 32'(wcnt_a - w0), 32'd4);
        check("stall_done_count",  32'(dcnt_a - d0), 32'd1);

        // Reset at cycle 5 of a transfer, then a clean restart.
        start_a = 1'b1; gnt_a = 1'b1;
        tick(); start_a = 1'b0;
        repeat (4) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clk);
        check("postrst_busy",     32'(busy_a), 32'd0);
        check("postrst_bus_req",  32'(req_a),  32'd0);
        check("postrst_ram_we",   32'(we_a),   32'd0);
        check("postrst_rom_n_cs", 32'(ncs_a),  32'd1);
        tick();
        w0 = wcnt_a; d0 = dcnt_a;
        start_a = 1'b1;
        tick(); start_a = 1'b0;
        run_until_done(0, 20, 0);
        check("restart_write_count", 32'(wcnt_a - w0), 32'd4);
        check("restart_done_count",  32'(dcnt_a - d0), 32'd1);

        // Single-byte window at the top of ROM.
        start_b = 1'b1; gnt_b = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            check($sformatf("b_c%0d_ram_we", c), 32'(we_b),   32'(c == 3));
            check($sformatf("b_c%0d_done", c),   32'(done_b), 32'(c == 4));
            check($sformatf("b_c%0d_busy", c),   32'(busy_b), 32'(c >= 1 && c <= 3));
            tick();
            start_b = 1'b0;
        end
        check("b_write_count", 32'(wcnt_b), 32'd1);
        check("b_done_count",  32'(dcnt_b), 32'd1);

        // Random grant and stray start pulses on the 4-byte window.
        for (int t = 0; t < 12; t++) begin
            w0 = wcnt_a; d0 = dcnt_a;
            start_a = 1'b1; gnt_a = 1'($urandom_range(0, 1));
            tick(); start_a = 1'b0;
            run_until_done(0, 200, 2);
            check($sformatf("rand%0d_writes", t), 32'(wcnt_a - w0), 32'd4);
            check($sformatf("rand%0d_dones", t),  32'(dcnt_a - d0), 32'd1);
            repeat (2) tick();
        end

        // Full 2K image with grant toggling every cycle.
        start_c = 1'b1; gnt_c = 1'b1;
        tick(); start_c = 1'b0;
        run_until_done(2, 6000, 1);
        mism = 0;
        for (int i = 0; i < 2048; i++) if (ram_c[i] !== rom_mem[i]) mism++;
        check("c_image_mismatches", 32'(mism), 32'd0);
        check("c_write_count", 32'(wcnt_c), 32'(C_W));
        check("c_done_count",  32'(dcnt_c), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
